// File: rtl/mwpipe_skid.sv
// M->W pipeline register with valid/ready handshake and a 2-entry skid buffer.
// Optional E-stage forwarding outputs are built when MWPIPE_FWD_EN is defined.
module mwpipe_skid #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              valid_M,
   output logic              ready_M,
   input  logic              pcload_M,
   input  logic              regw_M,
   input  logic              regmem_M,
   input  logic [REG_W-1:0]  regScr_M,
   input  logic [DATA_W-1:0] ALUrslt_M,
   input  logic [DATA_W-1:0] memRd_M,
   output logic              valid_W,
   input  logic              ready_W,
   output logic              pcload_W,
   output logic              regw_W,
   output logic              regmem_W,
   output logic [REG_W-1:0]  regScr_W,
   output logic [DATA_W-1:0] ALUrslt_W,
   output logic [DATA_W-1:0] memRd_W
`ifdef MWPIPE_FWD_EN
   ,
   output logic              fwd_valid,
   output logic [REG_W-1:0]  fwd_reg,
   output logic [DATA_W-1:0] fwd_data
`endif
);

   localparam int PW = 3 + REG_W + 2 * DATA_W;

   localparam logic [1:0] S_EMPTY = 2'd0;
   localparam logic [1:0] S_ONE   = 2'd1;
   localparam logic [1:0] S_FULL  = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [PW-1:0] main_q, main_d;
   logic [PW-1:0] skid_q, skid_d;
   logic          ready_q;
   logic [PW-1:0] in_pl;
   logic          in_xfer, out_xfer;
   logic          m_pcload, m_regw;

   assign in_pl = {pcload_M, regw_M, regmem_M,
                   regScr_M, ALUrslt_M, memRd_M};

   assign valid_W  = (state_q != S_EMPTY);
   assign ready_M  = ready_q;
   assign in_xfer  = valid_M & ready_q;
   assign out_xfer = valid_W & ready_W;

   assign {m_pcload, m_regw, regmem_W,
           regScr_W, ALUrslt_W, memRd_W} = main_q;

   // Bubbles must never write the register file or redirect the PC.
   assign pcload_W = m_pcload & valid_W;
   assign regw_W   = m_regw & valid_W;

   // Next-state and entry-load selection for the two-entry buffer.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = S_EMPTY;
      end else begin
         case (state_q)
            S_EMPTY: begin
               if (in_xfer) begin
                  main_d  = in_pl;
                  state_d = S_ONE;
               end
            end
            S_ONE: begin
               if (in_xfer && out_xfer) begin
                  main_d = in_pl;
               end else if (in_xfer) begin
                  skid_d  = in_pl;
                  state_d = S_FULL;
               end else if (out_xfer) begin
                  state_d = S_EMPTY;
               end
            end
            S_FULL: begin
               if (out_xfer) begin
                  main_d  = skid_q;
                  state_d = S_ONE;
               end
            end
            default: state_d = S_EMPTY;
         endcase
      end
   end

   // State, entries and the registered accept flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
         ready_q <= 1'b1;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
         ready_q <= (state_d != S_FULL);
      end
   end

`ifdef MWPIPE_FWD_EN
   assign fwd_valid = regw_W;
   assign fwd_reg   = regScr_W;
   assign fwd_data  = regmem_W ? memRd_W : ALUrslt_W;
`endif

endmodule

// File: tb/tb_mwpipe_skid.sv
// Self-checking bench for mwpipe_skid: queue model compared every cycle
// plus directed literal checks for reset, flow, stall, flush and bubbles.
module tb_mwpipe_skid;

   logic        clk = 1'b0;
   logic        rst_n, flush, valid_M, ready_M;
   logic        pcload_M, regw_M, regmem_M;
   logic [3:0]  regScr_M;
   logic [31:0] ALUrslt_M, memRd_M;
   logic        valid_W, ready_W;
   logic        pcload_W, regw_W, regmem_W;
   logic [3:0]  regScr_W;
   logic [31:0] ALUrslt_W, memRd_W;
`ifdef MWPIPE_FWD_EN
   logic        fwd_valid;
   logic [3:0]  fwd_reg;
   logic [31:0] fwd_data;
`endif

   always #5 clk = ~clk;

   mwpipe_skid #(.DATA_W(32), .REG_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .valid_M(valid_M), .ready_M(ready_M),
      .pcload_M(pcload_M), .regw_M(regw_M), .regmem_M(regmem_M),
      .regScr_M(regScr_M), .ALUrslt_M(ALUrslt_M), .memRd_M(memRd_M),
      .valid_W(valid_W), .ready_W(ready_W),
      .pcload_W(pcload_W), .regw_W(regw_W), .regmem_W(regmem_W),
      .regScr_W(regScr_W), .ALUrslt_W(ALUrslt_W), .memRd_W(memRd_W)
`ifdef MWPIPE_FWD_EN
      , .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_data(fwd_data)
`endif
   );

   typedef struct packed {
      logic        pc;
      logic        rw;
      logic        rm;
      logic [3:0]  rs;
      logic [31:0] alu;
      logic [31:0] mem;
   } item_t;

   item_t q[$];
   item_t last;
   bit    m_ready;
   int    n_total = 0;
   int    n_pass  = 0;

   function automatic item_t mk(bit pc, bit rw, bit rm, logic [3:0] rs,
                                logic [31:0] alu, logic [31:0] mem);
      item_t it;
      it.pc = pc; it.rw = rw; it.rm = rm;
      it.rs = rs; it.alu = alu; it.mem = mem;
      return it;
   endfunction

   task automatic chk(input string n, input logic [31:0] a,
                      input logic [31:0] e);
      n_total++;
      if (a === e) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
   endtask

   // Model: an ordered FIFO of capacity 2; front is what W sees.
   always @(posedge clk or negedge rst_n) begin
      bit    inx, outx;
      item_t it;
      if (!rst_n) begin
         q.delete();
         last    = '0;
         m_ready = 1'b1;
      end else begin
         inx  = valid_M && m_ready;
         outx = (q.size() > 0) && ready_W;
         it   = mk(pcload_M, regw_M, regmem_M, regScr_M, ALUrslt_M, memRd_M);
         if (flush) q.delete();
         else begin
            if (outx) void'(q.pop_front());
            if (inx) q.push_back(it);
         end
         if (q.size() > 0) last = q[0];
         m_ready = (q.size() < 2);
      end
   end

   // Compare process: every cycle, away from the active edge.
   always @(negedge clk) begin
      bit v;
      if (rst_n) begin
         v = (q.size() > 0);
         chk("valid_W", {31'd0, valid_W}, {31'd0, v});
         chk("ready_M", {31'd0, ready_M}, {31'd0, m_ready});
         chk("regw_W", {31'd0, regw_W}, {31'd0, v & last.rw});
         chk("pcload_W", {31'd0, pcload_W}, {31'd0, v & last.pc});
         chk("regmem_W", {31'd0, regmem_W}, {31'd0, last.rm});
         chk("regScr_W", {28'd0, regScr_W}, {28'd0, last.rs});
         chk("ALUrslt_W", ALUrslt_W, last.alu);
         chk("memRd_W", memRd_W, last.mem);
`ifdef MWPIPE_FWD_EN
         chk("fwd_valid", {31'd0, fwd_valid}, {31'd0, v & last.rw});
         chk("fwd_reg", {28'd0, fwd_reg}, {28'd0, last.rs});
         chk("fwd_data", fwd_data, last.rm ? last.mem : last.alu);
`endif
      end
   end

   task automatic drive(input bit v, input item_t it);
      valid_M = v;
      {pcload_M, regw_M, regmem_M, regScr_M, ALUrslt_M, memRd_M} = it;
      @(posedge clk);
      #2;
   endtask

   item_t A, B, C, nul;

   initial begin
      A   = mk(1'b0, 1'b1, 1'b0, 4'd5, 32'hAAAA_0001, 32'h0);
      B   = mk(1'b1, 1'b1, 1'b1, 4'd6, 32'hBBBB_0002, 32'h0000_B00B);
      C   = mk(1'b0, 1'b1, 1'b0, 4'd7, 32'hCCCC_0003, 32'h0);
      nul = '0;
      rst_n = 1'b0; flush = 1'b0; ready_W = 1'b1;
      valid_M = 1'b0; pcload_M = 1'b0; regw_M = 1'b0; regmem_M = 1'b0;
      regScr_M = '0; ALUrslt_M = '0; memRd_M = '0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      chk("lit_reset_valid", {31'd0, valid_W}, 32'd0);
      chk("lit_reset_ready", {31'd0, ready_M}, 32'd1);

      // Flow
      drive(1'b1, mk(1'b0, 1'b1, 1'b0, 4'b0011, 32'h0000FFFF, 32'h0));
      chk("lit_flow_valid", {31'd0, valid_W}, 32'd1);
      chk("lit_flow_reg", {28'd0, regScr_W}, 32'd3);
      chk("lit_flow_alu", ALUrslt_W, 32'h0000FFFF);
      for (int i = 1; i <= 4; i++) begin
         drive(1'b1, mk(1'b0, 1'b1, 1'b0, 4'(i), 32'h100 + 32'(i), 32'h0));
         chk("lit_b2b_alu", ALUrslt_W, 32'h100 + 32'(i));
      end
      drive(1'b0, nul);
      chk("lit_drain_valid", {31'd0, valid_W}, 32'd0);

      // Stall
      ready_W = 1'b0;
      drive(1'b1, A);
      drive(1'b1, B);
      chk("lit_stall_ready", {31'd0, ready_M}, 32'd0);
      chk("lit_stall_alu", ALUrslt_W, 32'hAAAA_0001);
      drive(1'b0, nul);
      chk("lit_hold_alu", ALUrslt_W, 32'hAAAA_0001);
      ready_W = 1'b1;
      drive(1'b0, nul);
      chk("lit_unstall_alu", ALUrslt_W, 32'hBBBB_0002);
      chk("lit_unstall_ready", {31'd0, ready_M}, 32'd1);
      drive(1'b0, nul);
      chk("lit_unstall_empty", {31'd0, valid_W}, 32'd0);

      // Flush while full, with C offered
      ready_W = 1'b0;
      drive(1'b1, A);
      drive(1'b1, B);
      flush = 1'b1;
      drive(1'b1, C);
      flush = 1'b0;
      chk("lit_flush_valid", {31'd0, valid_W}, 32'd0);
      chk("lit_flush_regw", {31'd0, regw_W}, 32'd0);
      chk("lit_flush_ready", {31'd0, ready_M}, 32'd1);
      ready_W = 1'b1;
      drive(1'b0, C);
      drive(1'b0, nul);
      chk("lit_flush_noC", ALUrslt_W, 32'hAAAA_0001);

      // Bubble with write controls asserted
      drive(1'b0, mk(1'b1, 1'b1, 1'b0, 4'd9, 32'h9, 32'h0));
      chk("lit_bubble_regw", {31'd0, regw_W}, 32'd0);
      chk("lit_bubble_pcl", {31'd0, pcload_W}, 32'd0);

`ifdef MWPIPE_FWD_EN
      drive(1'b1, mk(1'b0, 1'b1, 1'b1, 4'b0100, 32'h0000_AAAA, 32'h12345678));
      chk("lit_fwd_valid", {31'd0, fwd_valid}, 32'd1);
      chk("lit_fwd_reg", {28'd0, fwd_reg}, 32'd4);
      chk("lit_fwd_data", fwd_data, 32'h12345678);
`endif

      // Mixed traffic under model checking
      for (int i = 0; i < 40; i++) begin
         ready_W = 1'($urandom_range(0, 1));
         drive(1'($urandom_range(0, 1)),
               mk(1'($urandom), 1'($urandom), 1'($urandom),
                  4'($urandom), $urandom, $urandom));
      end

      // Asynchronous reset mid-transfer
      ready_W = 1'b0;
      drive(1'b1, A);
      drive(1'b1, B);
      #1 rst_n = 1'b0;
      #1;
      chk("lit_rst_valid", {31'd0, valid_W}, 32'd0);
      chk("lit_rst_regw", {31'd0, regw_W}, 32'd0);
      chk("lit_rst_alu", ALUrslt_W, 32'd0);
      valid_M = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b1;
      chk("lit_rst_ready", {31'd0, ready_M}, 32'd1);
      ready_W = 1'b1;
      drive(1'b1, C);
      chk("lit_post_rst_alu", ALUrslt_W, 32'hCCCC_0003);
      drive(1'b0, nul);
      drive(1'b0, nul);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
